byte_serial_add16: RTL and testbench

- Sequences a 16-bit add or subtract through the shared 8-bit full adder, low byte first, then high byte.
- Registers the inter-byte carry between the two passes.
- Sits directly around the adder: drives its operand and carry-in buses, and consumes its SUM/CO outputs.
- Used by address-step and accumulate paths that need 16-bit arithmetic without a second adder instance.

---
 rtl/byte_serial_add16.sv | 143 ++++++++++++++
 tb/tb_byte_serial_add16.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/byte_serial_add16.sv
// 16-bit add/subtract sequenced over an external shared 8-bit full adder.
// Low byte goes first; the inter-byte carry is held in a register for the high-byte pass.
module byte_serial_add16 #(
  parameter logic [15:0] ACC_INIT = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        SUB,
  input  logic        ACC,
  input  logic [15:0] A_IN,
  input  logic [15:0] B_IN,
  input  logic        CIN,
  output logic [7:0]  FA_A,
  output logic [7:0]  FA_B,
  output logic        FA_CI,
  input  logic [7:0]  FA_SUM,
  input  logic        FA_CO,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] RESULT,
  output logic        COUT,
  output logic        ZERO,
  output logic        OVF
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic        cy_q, cy_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] result_q, result_d;
  logic        cout_q, cout_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      opa_q    <= 16'h0000;
      opb_q    <= 16'h0000;
      cy_q     <= 1'b0;
      lo_q     <= 8'h00;
      result_q <= ACC_INIT;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cy_q     <= cy_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Adder operand mux depends only on registered state, never on FA_SUM/FA_CO.
  always_comb begin
    FA_A  = 8'h00;
    FA_B  = 8'h00;
    FA_CI = 1'b0;
    case (state_q)
      S_LO: begin
        FA_A  = opa_q[7:0];
        FA_B  = opb_q[7:0];
        FA_CI = cy_q;
      end
      S_HI: begin
        FA_A  = opa_q[15:8];
        FA_B  = opb_q[15:8];
        FA_CI = cy_q;
      end
      default: begin
        FA_A  = 8'h00;
        FA_B  = 8'h00;
        FA_CI = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cy_d     = cy_q;
    lo_d     = lo_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          opa_d   = ACC ? result_q : A_IN;
          opb_d   = SUB ? ~B_IN : B_IN;
          cy_d    = SUB ? 1'b1 : CIN;
          state_d = S_LO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LO: begin
        lo_d    = FA_SUM;
        cy_d    = FA_CO;
        state_d = S_HI;
      end
      S_HI: begin
        // All result fields commit together so RESULT is never half-updated.
        result_d = {FA_SUM, lo_q};
        cout_d   = FA_CO;
        zero_d   = ({FA_SUM, lo_q} == 16'h0000);
        ovf_d    = (opa_q[15] == opb_q[15]) && (FA_SUM[7] != opa_q[15]);
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign BUSY   = (state_q == S_LO) || (state_q == S_HI);
  assign DONE   = done_q;
  assign RESULT = result_q;
  assign COUT   = cout_q;
  assign ZERO   = zero_q;
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_byte_serial_add16.sv
// Scoreboard bench for byte_serial_add16: a behavioural 8-bit adder closes the loop,
// directed operations push hand-computed results, a negedge monitor checks each DONE.
module tb_byte_serial_add16;

  localparam logic [15:0] INIT_V = 16'h0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic        SUB = 1'b0;
  logic        ACC = 1'b0;
  logic [15:0] A_IN = 16'h0000;
  logic [15:0] B_IN = 16'h0000;
  logic        CIN = 1'b0;
  logic [7:0]  FA_A, FA_B, FA_SUM;
  logic        FA_CI, FA_CO;
  logic        BUSY, DONE, COUT, ZERO, OVF;
  logic [15:0] RESULT;

  byte_serial_add16 #(.ACC_INIT(INIT_V)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SUB(SUB), .ACC(ACC),
    .A_IN(A_IN), .B_IN(B_IN), .CIN(CIN),
    .FA_A(FA_A), .FA_B(FA_B), .FA_CI(FA_CI), .FA_SUM(FA_SUM), .FA_CO(FA_CO),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .COUT(COUT), .ZERO(ZERO), .OVF(OVF)
  );

  assign {FA_CO, FA_SUM} = {1'b0, FA_A} + {1'b0, FA_B} + {8'h00, FA_CI};

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        z;
    logic        o;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] hi_fa_a, hi_fa_b;
  logic       hi_fa_ci, hi_busy;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DONE must match the oldest expectation, at its exact cycle.
  always @(negedge CLK) begin
    if (DONE) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {16'h0000, RESULT}, {16'h0000, e.r});
        chk("cout", {31'd0, COUT}, {31'd0, e.c});
        chk("zero", {31'd0, ZERO}, {31'd0, e.z});
        chk("ovf", {31'd0, OVF}, {31'd0, e.o});
        chk("done_cycle", cyc, e.cyc);
      end
    end else if (sb.size() > 0 && cyc >= sb[0].cyc) begin
      void'(sb.pop_front());
      chk("missing_done", 32'd0, 32'd1);
    end
  end

  // Issue one op; returns #1 into the DONE cycle so the next op can start there.
  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                    input logic acc, input logic cin, input logic [15:0] er,
                    input logic ec, input logic ez, input logic eo);
    exp_t e;
    A_IN = a; B_IN = b; SUB = sub; ACC = acc; CIN = cin; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    e.r = er; e.c = ec; e.z = ez; e.o = eo; e.cyc = cyc + 2;
    sb.push_back(e);
    A_IN = ~a; B_IN = ~b; SUB = ~sub; ACC = ~acc; CIN = ~cin;
    @(posedge CLK); #1;
    hi_fa_a = FA_A; hi_fa_b = FA_B; hi_fa_ci = FA_CI; hi_busy = BUSY;
    @(posedge CLK); #1;
    ACC = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    chk("rst_result", {16'h0000, RESULT}, {16'h0000, INIT_V});
    chk("rst_flags", {28'd0, BUSY, DONE, COUT, ZERO}, 32'd0);
    chk("rst_ovf", {31'd0, OVF}, 32'd0);
    chk("rst_fa", {15'd0, FA_A, FA_B, FA_CI}, 32'd0);

    // Accumulate chain, each START in the previous DONE cycle
    op(16'h0000, 16'h4000, 1'b0, 1'b1, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b0);
    op(16'h0000, 16'h4000, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
    op(16'h0000, 16'h4000, 1'b0, 1'b1, 1'b0, 16'hC000, 1'b0, 1'b0, 1'b0);
    op(16'h0000, 16'h4000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

    // Byte carry propagation; inspect adder bus during HI
    op(16'h12FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h1300, 1'b0, 1'b0, 1'b0);
    chk("hi_fa_ci", {31'd0, hi_fa_ci}, 32'd1);
    chk("hi_fa_ab", {16'h0000, hi_fa_a, hi_fa_b}, 32'h0000_1200);
    chk("hi_busy", {31'd0, hi_busy}, 32'd1);

    op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    op(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b1);
    op(16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    op(16'h0005, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
    @(posedge CLK); #1;
    chk("done_one_cycle", {31'd0, DONE}, 32'd0);

    // START held high with A_IN changing every cycle: accepts at edges 0 and 3 only
    B_IN = 16'h0001; SUB = 1'b0; ACC = 1'b0; CIN = 1'b0; START = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      A_IN = 16'h1000 * (i + 1);
      @(posedge CLK); #1;
      if (i == 0 || i == 3) begin
        e.r = 16'h1001 * 16'(i + 1) - 16'(i) * 16'h0001; e.c = 1'b0; e.z = 1'b0; e.o = 1'b0;
        e.r = (i == 0) ? 16'h1001 : 16'h4001;
        e.cyc = cyc + 2;
        sb.push_back(e);
      end
      chk("busy_held", {31'd0, BUSY}, (i == 2 || i == 5) ? 32'd0 : 32'd1);
    end
    START = 1'b0;
    @(posedge CLK); #1;

    // Reset asserted while in HI: no DONE, everything back to reset values
    A_IN = 16'h1234; B_IN = 16'h1111; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    chk("pre_rst_busy", {31'd0, BUSY}, 32'd1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("midrst_result", {16'h0000, RESULT}, {16'h0000, INIT_V});
    chk("midrst_flags", {27'd0, BUSY, DONE, COUT, ZERO, OVF}, 32'd0);
    chk("midrst_fa", {15'd0, FA_A, FA_B, FA_CI}, 32'd0);
    repeat (2) @(posedge CLK); #1;
    op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

    repeat (4) @(posedge CLK); #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (2000) @(posedge CLK);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
